div_wb_queue: RTL and testbench

Result queue between the iterative divider and the writeback/commit port. It captures every divider result pulse, which the divider drives without backpressure, together with its transaction ID. It presents the results in order on a valid/ready writeback port. It also tracks in-flight divide operations and produces an issue credit, so the issue stage never launches a divide whose result could not be stored.

---
 rtl/div_wb_queue_pkg.sv | 5 +
 rtl/div_wb_queue_fifo_v.sv | 70 +++++++
 rtl/div_wb_queue.sv | 83 ++++++++
 tb/tb_div_wb_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_wb_queue_pkg.sv
// Shared constants for the divider writeback queue slice.
package div_wb_queue_pkg;
  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned DATA_BITS = 32;
endpackage

// File: rtl/div_wb_queue_fifo_v.sv
// Generic circular FIFO with flush; head is read combinationally from rd_ptr.
module fifo_v #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 36,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   usage_o
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign usage_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/div_wb_queue.sv
// Divider result queue: buffers unstallable result pulses, presents them on a
// valid/ready writeback port and issues credits covering in-flight divides.
module div_wb_queue
  import div_wb_queue_pkg::*;
#(
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned ADDR_BITS = div_wb_queue_pkg::ADDR_BITS,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_ex_i,
  input  logic                 issue_hsk_i,
  input  logic                 res_vld_i,
  input  logic [ADDR_BITS-1:0] res_trans_id_i,
  input  logic [DATA_BITS-1:0] res_data_i,
  output logic                 issue_ok_o,
  output logic                 wb_vld_o,
  input  logic                 wb_rdy_i,
  output logic [ADDR_BITS-1:0] wb_trans_id_o,
  output logic [DATA_BITS-1:0] wb_data_o,
  output logic                 ovf_err_o
);
  localparam int unsigned   WIDTH     = ADDR_BITS + DATA_BITS;
  localparam logic [PTR_W+1:0] DEPTH_SUM = (PTR_W + 2)'(DEPTH);

  logic             full, empty, push, pop, drop;
  logic [PTR_W:0]   usage;
  logic [WIDTH-1:0] head;
  logic [PTR_W:0]   inflight_q, inflight_d;
  logic             ovf_err_q, ovf_err_d;

  assign pop  = wb_vld_o & wb_rdy_i;
  assign push = res_vld_i & (~full | pop);
  assign drop = res_vld_i & full & ~pop & ~flush_ex_i;

  fifo_v #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_ex_i),
    .push_i  (push),
    .data_i  ({res_trans_id_i, res_data_i}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage)
  );

  // Issue+result in one cycle nets to zero; a stray result saturates at 0.
  always_comb begin
    inflight_d = inflight_q;
    ovf_err_d  = ovf_err_q | drop;
    if (flush_ex_i) begin
      inflight_d = '0;
    end else begin
      unique case ({issue_hsk_i, res_vld_i})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign issue_ok_o    = ({1'b0, usage} + {1'b0, inflight_q}) < DEPTH_SUM;
  assign wb_vld_o      = ~empty;
  assign wb_trans_id_o = head[WIDTH-1 -: ADDR_BITS];
  assign wb_data_o     = head[DATA_BITS-1:0];
  assign ovf_err_o     = ovf_err_q;
endmodule

// File: tb/tb_div_wb_queue.sv
// Directed bench: stimulus pushes expected results into a scoreboard queue,
// a negedge monitor compares the writeback head against it.
module tb_div_wb_queue;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_ex_i = 1'b0;
  logic        issue_hsk_i = 1'b0;
  logic        res_vld_i = 1'b0;
  logic [3:0]  res_trans_id_i = '0;
  logic [31:0] res_data_i = '0;
  logic        issue_ok_o, wb_vld_o, ovf_err_o;
  logic        wb_rdy_i = 1'b0;
  logic [3:0]  wb_trans_id_o;
  logic [31:0] wb_data_o;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  div_wb_queue #(.DEPTH(4), .ADDR_BITS(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_ex_i     (flush_ex_i),
    .issue_hsk_i    (issue_hsk_i),
    .res_vld_i      (res_vld_i),
    .res_trans_id_i (res_trans_id_i),
    .res_data_i     (res_data_i),
    .issue_ok_o     (issue_ok_o),
    .wb_vld_o       (wb_vld_o),
    .wb_rdy_i       (wb_rdy_i),
    .wb_trans_id_o  (wb_trans_id_o),
    .wb_data_o      (wb_data_o),
    .ovf_err_o      (ovf_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one result for the coming edge; 'keep' says whether it must reach writeback.
  task automatic set_res(input logic [3:0] id, input logic [31:0] data, input bit keep);
    res_vld_i      = 1'b1;
    res_trans_id_i = id;
    res_data_i     = data;
    if (keep) exp_q.push_back({id, data});
  endtask

  task automatic clr();
    res_vld_i   = 1'b0;
    issue_hsk_i = 1'b0;
    flush_ex_i  = 1'b0;
  endtask

  // Monitor: every presented head must match the scoreboard front (also proves stall stability).
  always @(negedge clk_i) begin
    if (rst_ni && !flush_ex_i && wb_vld_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: actual id=%0h data=%0h required=no output", wb_trans_id_o, wb_data_o);
      end else if ({wb_trans_id_o, wb_data_o} !== exp_q[0]) begin
        errors++;
        $display("FAIL wb_head: actual id=%0h data=%0h required id=%0h data=%0h",
                 wb_trans_id_o, wb_data_o, exp_q[0][35:32], exp_q[0][31:0]);
        if (wb_rdy_i) void'(exp_q.pop_front());
      end else begin
        $display("ok   wb_head id=%0h data=%0h rdy=%0b", wb_trans_id_o, wb_data_o, wb_rdy_i);
        if (wb_rdy_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #12;
    chk("rst_wb_vld", 32'(wb_vld_o), 32'd0);
    chk("rst_issue_ok", 32'(issue_ok_o), 32'd1);
    chk("rst_ovf", 32'(ovf_err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();

    // Single result, also a stray result with nothing in flight
    wb_rdy_i = 1'b1;
    set_res(4'd3, 32'h7, 1'b1);
    cyc(); clr();
    chk("single_vld_n1", 32'(wb_vld_o), 32'd1);
    cyc();
    chk("single_vld_n2", 32'(wb_vld_o), 32'd0);
    chk("single_issue_ok", 32'(issue_ok_o), 32'd1);

    // Fill under backpressure, then drain in order
    wb_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_hsk_i = 1'b1;
      cyc(); clr();
      set_res(4'(i), 32'h100 + 32'(i), 1'b1);
      cyc(); clr();
    end
    chk("fill_issue_ok", 32'(issue_ok_o), 32'd0);
    chk("fill_vld", 32'(wb_vld_o), 32'd1);
    repeat (3) cyc();
    wb_rdy_i = 1'b1;
    repeat (4) cyc();
    wb_rdy_i = 1'b0;
    chk("drain_vld", 32'(wb_vld_o), 32'd0);
    chk("drain_issue_ok", 32'(issue_ok_o), 32'd1);

    // Credit with an in-flight divide
    for (int i = 4; i < 7; i++) begin
      set_res(4'(i), 32'h200 + 32'(i), 1'b1);
      cyc(); clr();
    end
    chk("credit_3q", 32'(issue_ok_o), 32'd1);
    issue_hsk_i = 1'b1;
    cyc(); clr();
    chk("credit_3q_1if", 32'(issue_ok_o), 32'd0);
    set_res(4'd7, 32'h207, 1'b1);
    cyc(); clr();
    chk("credit_4q", 32'(issue_ok_o), 32'd0);
    chk("credit_ovf", 32'(ovf_err_o), 32'd0);
    wb_rdy_i = 1'b1;
    cyc();
    wb_rdy_i = 1'b0;
    chk("credit_after_pop", 32'(issue_ok_o), 32'd1);
    wb_rdy_i = 1'b1;
    repeat (3) cyc();
    wb_rdy_i = 1'b0;
    chk("credit_empty", 32'(wb_vld_o), 32'd0);

    // Fast path: inflight must stay 0 so three more issues exhaust credit exactly
    issue_hsk_i = 1'b1;
    set_res(4'd8, 32'h308, 1'b1);
    cyc(); clr();
    chk("fast_issue_ok", 32'(issue_ok_o), 32'd1);
    issue_hsk_i = 1'b1;
    repeat (2) cyc();
    clr();
    chk("fast_1q_2if", 32'(issue_ok_o), 32'd1);
    issue_hsk_i = 1'b1;
    cyc(); clr();
    chk("fast_1q_3if", 32'(issue_ok_o), 32'd0);
    for (int i = 9; i < 12; i++) begin
      set_res(4'(i), 32'h300 + 32'(i), 1'b1);
      cyc(); clr();
    end
    chk("fast_full", 32'(issue_ok_o), 32'd0);

    // Full: push with simultaneous pop is accepted; without pop it is dropped
    wb_rdy_i = 1'b1;
    set_res(4'd12, 32'h40c, 1'b1);
    cyc(); clr();
    wb_rdy_i = 1'b0;
    chk("full_pp_ovf", 32'(ovf_err_o), 32'd0);
    chk("full_pp_issue_ok", 32'(issue_ok_o), 32'd0);
    set_res(4'd13, 32'h40d, 1'b0);
    cyc(); clr();
    chk("full_drop_ovf", 32'(ovf_err_o), 32'd1);

    // Flush with 2 queued, 1 in flight and a same-cycle result
    wb_rdy_i = 1'b1;
    repeat (2) cyc();
    wb_rdy_i = 1'b0;
    issue_hsk_i = 1'b1;
    cyc(); clr();
    chk("pre_flush_issue_ok", 32'(issue_ok_o), 32'd1);
    flush_ex_i = 1'b1;
    set_res(4'd14, 32'h50e, 1'b0);
    exp_q.delete();
    cyc(); clr();
    chk("flush_vld", 32'(wb_vld_o), 32'd0);
    chk("flush_issue_ok", 32'(issue_ok_o), 32'd1);
    chk("flush_ovf_sticky", 32'(ovf_err_o), 32'd1);
    wb_rdy_i = 1'b1;
    repeat (2) cyc();
    set_res(4'd15, 32'hdead_beef, 1'b1);
    cyc(); clr();
    cyc();
    chk("post_flush_vld", 32'(wb_vld_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-operation
    wb_rdy_i = 1'b0;
    set_res(4'd1, 32'h1, 1'b0);
    cyc(); clr();
    #2 rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_vld", 32'(wb_vld_o), 32'd0);
    chk("async_rst_ovf", 32'(ovf_err_o), 32'd0);
    chk("async_rst_issue_ok", 32'(issue_ok_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
